axi4s_pkt_rr_arb: RTL and testbench
===================================

# axi4s_pkt_rr_arb

Packet-level round-robin arbiter that shares one `{error,numbytes}`-tagged AXI4-Stream datapath, such as a header-stripping remove-bytes stage, between `NUM_PORTS` requesters. Grants are held for a whole packet, from the first word through `tlast`, so the downstream byte-removal logic always sees contiguous, unmixed packets. The block sits directly upstream of the shared datapath and provides:
- a registered output stage;
- a source-ID sideband;
- per-port enable configuration;
- an error-packet counter.

## Interface
Parameters:
- `NUM_PORTS`, 4, number of requesting input streams (2..16).
- `DATA_WIDTH`, 64, tdata width in bits (multiple of 8).
- `USER_WIDTH`, `$clog2(DATA_WIDTH/8)+1`, tuser width `{error, numbytes}`.
  - MSB = MAC error.
  - numbytes 0 means a full word.
- `SRC_W`, `$clog2(NUM_PORTS)`, source-ID width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `port_en`  in  `NUM_PORTS`  per-port enable; sampled only at arbitration.
- `i_tdata`  in  `NUM_PORTS*DATA_WIDTH`  port k at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `i_tuser`  in  `NUM_PORTS*USER_WIDTH`  packed the same way as `i_tdata`.
- `i_tlast`  in  `NUM_PORTS`  end of packet.
- `i_tvalid`  in  `NUM_PORTS`  word valid.
- `i_tready`  out  `NUM_PORTS`  word accepted.
- `o_tdata`  out  `DATA_WIDTH`  registered output data.
- `o_tuser`  out  `USER_WIDTH`  registered; passed through unmodified.
- `o_tlast`  out  1  registered.
- `o_tvalid`  out  1  registered.
- `o_tready`  in  1  downstream ready.
- `o_src`  out  `SRC_W`  index of the port that supplied the current output word.
- `err_cnt`  out  16  count of accepted packets whose `tlast` word has tuser MSB = 1; saturates at 0xFFFF.

## Operation
- Request vector `req = i_tvalid & port_en`.
- State machine: `ST_IDLE`, `ST_PASS`.
- **`ST_IDLE` behaviour:**
  - All `i_tready` = 0.
  - If `req` ≠ 0, select the first set bit searching upward from `last_grant+1` (mod `NUM_PORTS`).
  - Register `grant` ← selected index, go to `ST_PASS`.
  - If `req` = 0, stay in `ST_IDLE`.
- **`ST_PASS` behaviour:**
  - `i_tready[grant] = !o_tvalid || o_tready`; all other `i_tready` = 0.
  - On accept (`i_tvalid[grant] && i_tready[grant]`), the output register loads tdata, tuser and tlast, sets `o_tvalid` = 1, and sets `o_src` = `grant`.
  - On an accepted word with tlast = 1: `last_grant` ← `grant`, go to `ST_IDLE`.
- Output register: if there is no load and `o_tready` = 1, `o_tvalid` ← 0. Data fields hold their last value.
- `port_en` deassertion on the granted port mid-packet does not cut the packet. It takes effect at the next `ST_IDLE` evaluation.
- A port that drops `i_tvalid` mid-packet keeps the grant. The arbiter waits indefinitely and never times out.
- `err_cnt` increments by 1 on each accepted input word with tlast = 1 and `i_tuser[grant]` MSB = 1, unless it equals 0xFFFF. The counter is cleared only by `rst`.
- Single-word packets (tlast on the first word) return to `ST_IDLE` after one `ST_PASS` word.

## Timing
- Reset values (asserted asynchronously, released on `clk`):
  - state = `ST_IDLE`;
  - `last_grant` = `NUM_PORTS-1`, so port 0 wins first;
  - `grant` = 0;
  - `o_tvalid` = 0, `o_tlast` = 0, `o_tdata` = 0, `o_tuser` = 0, `o_src` = 0;
  - `err_cnt` = 0;
  - `i_tready` = 0.
- Arbitration latency is 1 cycle: `req` seen in cycle N, first `i_tready` high in N+1.
- Data latency is 1 cycle: a word accepted in cycle N appears on `o_*` in N+1.
- Throughput:
  - a W-word packet occupies W+1 cycles when `o_tready` is held high (one idle bubble per packet);
  - full rate within a packet.
- `i_tready` depends combinationally on `o_tready` and registered state only. It never depends on `i_tvalid`.
- `o_tvalid`, once high, stays high with stable data until `o_tready` is sampled high.
- Reset mid-packet: the output is squashed (`o_tvalid` = 0) and the partial packet is abandoned. Upstream must also be reset.

## Test plan
- **Port 0 alone:** 3-word packet on port 0 (tuser 0,0,3), `o_tready` = 1 → `i_tready[0]` high cycles 1–3; `o_*` words in cycles 2–4 with `o_src` = 0; `o_tlast` only on word 3; `err_cnt` = 0.
- **Round-robin fairness:** ports 0–3 all continuously requesting 2-word packets → output order 0,1,2,3,0,…; each packet is contiguous; 3 cycles per packet.
- **Backpressure:**
  - `o_tready` toggling 1/0 during a 4-word packet from port 2 → no loss or duplication; `o_tdata` stable while stalled.
  - `i_tready[2]` = 0 whenever `o_tvalid && !o_tready`.
- **Enable mask:** `port_en` = 4'b1011 with all ports requesting → port 2 never granted. Clearing `port_en[1]` mid-packet on port 1 → that packet completes, then port 1 is skipped.
- **Error counting:** 3 packets with tuser MSB = 1 on tlast, plus one packet with the error bit only on a non-last word → `err_cnt` = 3. Counter preloaded near saturation stays at 0xFFFF.
- **Reset mid-packet:** assert `rst` during word 2 of a 5-word packet on port 3 → `o_tvalid` drops immediately. After release, port 0 is granted first when all ports request.

Source files
------------

// File: rtl/axi4s_pkt_rr_arb.sv
// Packet-level round-robin arbiter for {error,numbytes}-tagged AXI4-Stream ports.
// A grant is held from the first word through tlast; the output stage is registered.
module axi4s_pkt_rr_arb #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = $clog2(DATA_WIDTH/8)+1,
    parameter int SRC_W      = $clog2(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             port_en,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  i_tdata,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]  i_tuser,
    input  logic [NUM_PORTS-1:0]             i_tlast,
    input  logic [NUM_PORTS-1:0]             i_tvalid,
    output logic [NUM_PORTS-1:0]             i_tready,
    output logic [DATA_WIDTH-1:0]            o_tdata,
    output logic [USER_WIDTH-1:0]            o_tuser,
    output logic                             o_tlast,
    output logic                             o_tvalid,
    input  logic                             o_tready,
    output logic [SRC_W-1:0]                 o_src,
    output logic [15:0]                      err_cnt
);

    typedef enum logic {ST_IDLE, ST_PASS} state_t;

    state_t                 state;
    logic [SRC_W-1:0]       grant;
    logic [SRC_W-1:0]       last_grant;
    logic [SRC_W-1:0]       sel_idx;
    logic [SRC_W-1:0]       cand;
    logic                   sel_found;
    logic [NUM_PORTS-1:0]   req;
    logic                   out_free;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  g_tdata;
    logic [USER_WIDTH-1:0]  g_tuser;
    logic                   g_tlast;
    logic                   g_tvalid;
    logic [15:0]            err_q;

    assign req      = i_tvalid & port_en;
    assign out_free = !o_tvalid || o_tready;
    assign accept   = (state == ST_PASS) && g_tvalid && out_free;
    assign err_cnt  = err_q;

    // Rotating search starting one past the last port that finished a packet.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = last_grant;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = (cand == SRC_W'(NUM_PORTS-1)) ? '0 : cand + 1'b1;
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        g_tdata  = '0;
        g_tuser  = '0;
        g_tlast  = 1'b0;
        g_tvalid = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant == SRC_W'(k)) begin
                g_tdata  = i_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                g_tuser  = i_tuser[k*USER_WIDTH +: USER_WIDTH];
                g_tlast  = i_tlast[k];
                g_tvalid = i_tvalid[k];
            end
        end
    end

    // Ready never looks at tvalid, only at registered state and downstream ready.
    always_comb begin
        i_tready = '0;
        if (state == ST_PASS) begin
            i_tready[grant] = out_free;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= SRC_W'(NUM_PORTS-1);
            o_tdata    <= '0;
            o_tuser    <= '0;
            o_tlast    <= 1'b0;
            o_tvalid   <= 1'b0;
            o_src      <= '0;
            err_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        grant <= sel_idx;
                        state <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (accept && g_tlast) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (accept) begin
                o_tdata  <= g_tdata;
                o_tuser  <= g_tuser;
                o_tlast  <= g_tlast;
                o_tvalid <= 1'b1;
                o_src    <= grant;
            end else if (o_tready) begin
                o_tvalid <= 1'b0;
            end

            if (accept && g_tlast && g_tuser[USER_WIDTH-1] && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi4s_pkt_rr_arb.sv
// Directed bench for axi4s_pkt_rr_arb: per-port packet sources, output beat log,
// and immediate-assertion checks of ordering, backpressure, masking and error counts.
module tb_axi4s_pkt_rr_arb;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int UW = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     port_en;
    logic [NP*DW-1:0]  i_tdata;
    logic [NP*UW-1:0]  i_tuser;
    logic [NP-1:0]     i_tlast;
    logic [NP-1:0]     i_tvalid;
    logic [NP-1:0]     i_tready;
    logic [DW-1:0]     o_tdata;
    logic [UW-1:0]     o_tuser;
    logic              o_tlast;
    logic              o_tvalid;
    logic              o_tready;
    logic [SW-1:0]     o_src;
    logic [15:0]       err_cnt;

    int checks = 0;
    int errors = 0;

    // Source model state per port.
    int        pkt_len[NP];
    int        word_idx[NP];
    int        pkt_num[NP];
    int        pkts_left[NP];
    logic [7:0] err_words[NP];

    // Log of output beats consumed downstream.
    logic [SW-1:0] log_src[$];
    logic [DW-1:0] log_data[$];
    logic          log_last[$];
    logic [UW-1:0] log_user[$];
    int            log_cyc[$];

    int        cyc;
    int        stall_cnt;
    logic      prev_stall;
    logic [DW-1:0] prev_data;

    always #5 clk = ~clk;

    axi4s_pkt_rr_arb #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .SRC_W      (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .port_en  (port_en),
        .i_tdata  (i_tdata),
        .i_tuser  (i_tuser),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tuser  (o_tuser),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .o_src    (o_src),
        .err_cnt  (err_cnt)
    );

    function automatic logic [DW-1:0] enc(int p, int n, int w);
        return {16'hA5A5, 8'(p), 24'(n), 16'(w)};
    endfunction

    function automatic int next_src(int last, logic [NP-1:0] mask);
        for (int i = 1; i <= NP; i++) begin
            if (mask[(last + i) % NP]) return (last + i) % NP;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            i_tvalid[p]          = (pkts_left[p] > 0);
            i_tlast[p]           = (word_idx[p] == pkt_len[p] - 1);
            i_tdata[p*DW +: DW]  = enc(p, pkt_num[p], word_idx[p]);
            i_tuser[p*UW +: UW]  = {err_words[p][word_idx[p]], i_tlast[p] ? 3'd3 : 3'd0};
        end
    endtask

    // One clock: sample handshakes and outputs at negedge, advance sources after posedge.
    task automatic tick();
        logic [NP-1:0] acc;
        @(negedge clk);
        acc = i_tvalid & i_tready;
        if (o_tvalid && !o_tready) chk("stall_iready_low", i_tready, 0);
        if (prev_stall) begin
            chk("stall_hold_valid", o_tvalid, 1);
            chk("stall_hold_data", o_tdata, prev_data);
        end
        prev_stall = o_tvalid && !o_tready;
        prev_data  = o_tdata;
        if (prev_stall) stall_cnt++;
        if (o_tvalid && o_tready) begin
            log_src.push_back(o_src);
            log_data.push_back(o_tdata);
            log_last.push_back(o_tlast);
            log_user.push_back(o_tuser);
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                if (word_idx[p] == pkt_len[p] - 1) begin
                    word_idx[p] = 0;
                    pkt_num[p]++;
                    pkts_left[p]--;
                end else begin
                    word_idx[p]++;
                end
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        o_tready = 1'b1;
        port_en  = '1;
        for (int p = 0; p < NP; p++) begin
            pkt_len[p]   = 1;
            word_idx[p]  = 0;
            pkt_num[p]   = 0;
            pkts_left[p] = 0;
            err_words[p] = '0;
        end
        drive();
        log_src.delete();
        log_data.delete();
        log_last.delete();
        log_user.delete();
        log_cyc.delete();
        prev_stall = 1'b0;
        stall_cnt  = 0;
        cyc        = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cut;
        int npk;
        int last;
        int cnt[NP];
        int exp_s;
        logic found;
        logic [NP-1:0] mask;

        // Reset state
        do_reset();
        chk("rst_o_tvalid", o_tvalid, 0);
        chk("rst_o_tlast", o_tlast, 0);
        chk("rst_o_tdata", o_tdata, 0);
        chk("rst_o_tuser", o_tuser, 0);
        chk("rst_o_src", o_src, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_i_tready", i_tready, 0);

        // Port 0 alone, 3-word packet
        pkt_len[0] = 3;
        pkts_left[0] = 1;
        drive();
        chk("p0_c0_iready", i_tready, 0);
        tick();
        chk("p0_c1_iready", i_tready, 4'b0001);
        chk("p0_c1_ovalid", o_tvalid, 0);
        tick();
        chk("p0_c2_iready", i_tready, 4'b0001);
        chk("p0_c2_ovalid", o_tvalid, 1);
        chk("p0_c2_data", o_tdata, enc(0, 0, 0));
        chk("p0_c2_src", o_src, 0);
        chk("p0_c2_last", o_tlast, 0);
        chk("p0_c2_user", o_tuser, 0);
        tick();
        chk("p0_c3_iready", i_tready, 4'b0001);
        chk("p0_c3_data", o_tdata, enc(0, 0, 1));
        chk("p0_c3_last", o_tlast, 0);
        tick();
        chk("p0_c4_iready", i_tready, 0);
        chk("p0_c4_data", o_tdata, enc(0, 0, 2));
        chk("p0_c4_last", o_tlast, 1);
        chk("p0_c4_user", o_tuser, 3);
        tick();
        chk("p0_c5_ovalid", o_tvalid, 0);
        chk("p0_err_cnt", err_cnt, 0);

        // Round-robin fairness, 2-word packets on all ports
        do_reset();
        for (int p = 0; p < NP; p++) begin
            pkt_len[p] = 2;
            pkts_left[p] = 1000;
        end
        drive();
        repeat (30) tick();
        chk("rr_beats_enough", log_src.size() >= 16, 1);
        if (log_src.size() >= 16) begin
            for (int k = 0; k < 16; k++) begin
                chk("rr_src", log_src[k], (k / 2) % NP);
                chk("rr_data", log_data[k], enc((k / 2) % NP, k / 8, k % 2));
                chk("rr_last", log_last[k], k % 2);
                if (k >= 2) chk("rr_period", log_cyc[k] - log_cyc[k-2], 3);
            end
        end

        // Backpressure on a 4-word packet from port 2
        do_reset();
        pkt_len[2] = 4;
        pkts_left[2] = 1;
        drive();
        for (int i = 0; i < 16; i++) begin
            tick();
            o_tready = ~o_tready;
        end
        o_tready = 1'b1;
        repeat (3) tick();
        chk("bp_stalls_seen", stall_cnt > 0, 1);
        chk("bp_beat_count", log_src.size(), 4);
        if (log_src.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("bp_src", log_src[k], 2);
                chk("bp_data", log_data[k], enc(2, 0, k));
                chk("bp_last", log_last[k], k == 3);
            end
        end

        // Enable mask 1011, then drop port 1 mid-packet
        do_reset();
        port_en = 4'b1011;
        for (int p = 0; p < NP; p++) begin
            pkt_len[p] = 2;
            pkts_left[p] = 1000;
        end
        drive();
        repeat (20) tick();
        found = 1'b0;
        cut = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i_tready[1]) begin
                found = 1'b1;
                break;
            end
        end
        chk("en_port1_granted", found, 1);
        foreach (log_last[k]) if (log_last[k]) cut++;
        port_en[1] = 1'b0;
        repeat (20) tick();
        npk = log_src.size() / 2;
        chk("en_pkts_after_cut", npk >= cut + 5, 1);
        if (found && npk > cut) chk("en_cut_pkt_src", log_src[2*cut], 1);
        last = NP - 1;
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        for (int j = 0; j < npk; j++) begin
            mask = (j <= cut) ? 4'b1011 : 4'b1001;
            exp_s = next_src(last, mask);
            chk("en_src_w0", log_src[2*j], exp_s);
            chk("en_src_w1", log_src[2*j+1], exp_s);
            chk("en_data_w0", log_data[2*j], enc(exp_s, cnt[exp_s], 0));
            chk("en_data_w1", log_data[2*j+1], enc(exp_s, cnt[exp_s], 1));
            cnt[exp_s]++;
            last = exp_s;
        end

        // Error counting
        do_reset();
        pkt_len[0] = 1;
        pkts_left[0] = 3;
        err_words[0] = 8'h01;
        pkt_len[1] = 2;
        pkts_left[1] = 1;
        err_words[1] = 8'h01;
        drive();
        repeat (15) tick();
        chk("err_beat_count", log_src.size(), 5);
        chk("err_cnt_three", err_cnt, 3);
        if (log_src.size() == 5) begin
            chk("err_user_p0", log_user[0], 4'hB);
            chk("err_user_p1w0", log_user[1], 4'h8);
            chk("err_user_p1w1", log_user[2], 4'h3);
            chk("err_order", {log_src[0], log_src[1], log_src[3], log_src[4]}, 8'b00_01_00_00);
        end
        dut.err_q = 16'hFFFE;
        pkts_left[0] = 3;
        drive();
        repeat (10) tick();
        chk("err_cnt_saturate", err_cnt, 16'hFFFF);

        // Reset during a 5-word packet on port 3
        do_reset();
        pkt_len[3] = 5;
        pkts_left[3] = 1;
        drive();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (word_idx[3] == 2) begin
                found = 1'b1;
                break;
            end
        end
        chk("rstmid_reached_word2", found, 1);
        chk("rstmid_pre_ovalid", o_tvalid, 1);
        chk("rstmid_pre_src", o_src, 3);
        rst = 1'b1;
        #1;
        chk("rstmid_ovalid_squash", o_tvalid, 0);
        chk("rstmid_iready_zero", i_tready, 0);
        do_reset();
        for (int p = 0; p < NP; p++) pkts_left[p] = 1;
        drive();
        tick();
        chk("rstmid_first_grant", i_tready, 4'b0001);
        repeat (10) tick();
        chk("rstmid_beats", log_src.size(), 4);
        if (log_src.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("rstmid_order", log_src[k], k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
